// File: rtl/instructions_pager.sv
// Instruction-screen pager: steps through pages stored back-to-back in one image BROM,
// producing the registered pixel address and a sprite-valid flag aligned to ROM data.
module instructions_pager #(
  parameter int WIDTH          = 200,
  parameter int HEIGHT         = 200,
  parameter int NUM_PAGES      = 4,
  parameter int TIMEOUT_FRAMES = 600,
  parameter int ROM_LATENCY    = 2
) (
  input  logic                                      pixel_clk_in,
  input  logic                                      rst_in,
  input  logic [10:0]                               x_in,
  input  logic [9:0]                                y_in,
  input  logic [10:0]                               hcount_in,
  input  logic [9:0]                                vcount_in,
  input  logic                                      new_frame_in,
  input  logic                                      enable_in,
  input  logic                                      next_in,
  input  logic                                      prev_in,
  output logic [$clog2(WIDTH*HEIGHT*NUM_PAGES)-1:0] image_addr_out,
  output logic                                      in_sprite_out,
  output logic [$clog2(NUM_PAGES)-1:0]              page_out,
  output logic                                      done_out,
  output logic                                      busy_out
);

  localparam int ADDR_W = $clog2(WIDTH*HEIGHT*NUM_PAGES);
  localparam int PAGE_W = $clog2(NUM_PAGES);
  localparam int CNT_W  = $clog2(TIMEOUT_FRAMES + 2);
  localparam int DLY    = 1 + ROM_LATENCY;

  typedef enum logic [1:0] {IDLE, SHOW, PENDING, DONE} state_t;

  state_t            state;
  logic [PAGE_W-1:0] target;
  logic              target_finish;
  logic [CNT_W-1:0]  frame_cnt;
  logic [DLY-1:0]    valid_dly;

  // One extra bit on the right/bottom edges so a page near the raster limit cannot wrap.
  logic [11:0]       x_end;
  logic [10:0]       y_end;
  logic              in_page;
  logic [10:0]       rel_x;
  logic [9:0]        rel_y;
  logic [ADDR_W-1:0] pixel_addr;

  assign x_end   = {1'b0, x_in} + 12'(WIDTH);
  assign y_end   = {1'b0, y_in} + 11'(HEIGHT);
  assign in_page = (hcount_in >= x_in) && ({1'b0, hcount_in} < x_end) &&
                   (vcount_in >= y_in) && ({1'b0, vcount_in} < y_end);
  assign rel_x   = hcount_in - x_in;
  assign rel_y   = vcount_in - y_in;
  assign pixel_addr = ADDR_W'(page_out) * ADDR_W'(WIDTH*HEIGHT) + ADDR_W'(rel_x)
                    + ADDR_W'(rel_y) * ADDR_W'(WIDTH);

  logic btn_next, btn_prev, timeout, go_next, go_prev, last_page;

  assign btn_next  = next_in & ~prev_in;
  assign btn_prev  = prev_in & ~next_in;
  assign timeout   = (TIMEOUT_FRAMES != 0) && (frame_cnt == CNT_W'(TIMEOUT_FRAMES));
  assign go_prev   = btn_prev && (page_out != '0);
  assign go_next   = btn_next || (timeout && !go_prev);
  assign last_page = (page_out == PAGE_W'(NUM_PAGES - 1));

  assign busy_out      = (state == SHOW) || (state == PENDING);
  assign in_sprite_out = valid_dly[DLY-1] & busy_out;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      page_out      <= '0;
      target        <= '0;
      target_finish <= 1'b0;
      frame_cnt     <= '0;
      done_out      <= 1'b0;
    end else begin
      done_out <= 1'b0;
      if (!enable_in) begin
        state         <= IDLE;
        page_out      <= '0;
        frame_cnt     <= '0;
        target        <= '0;
        target_finish <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            state     <= SHOW;
            page_out  <= '0;
            frame_cnt <= '0;
          end
          SHOW: begin
            if (new_frame_in && (frame_cnt != '1)) frame_cnt <= frame_cnt + CNT_W'(1);
            if (go_prev) begin
              target        <= page_out - PAGE_W'(1);
              target_finish <= 1'b0;
              state         <= PENDING;
            end else if (go_next) begin
              target        <= page_out + PAGE_W'(1);
              target_finish <= last_page;
              state         <= PENDING;
            end
          end
          PENDING: begin
            // Page swaps wait for vblank so a frame is never drawn from two pages.
            if (new_frame_in) begin
              if (target_finish) begin
                done_out <= 1'b1;
                state    <= DONE;
              end else begin
                page_out  <= target;
                frame_cnt <= '0;
                state     <= SHOW;
              end
            end
          end
          DONE: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // NOTE: the valid delay line is cleared on reset so no stale pixel is flagged after reset.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      image_addr_out <= '0;
      valid_dly      <= '0;
    end else begin
      image_addr_out <= in_page ? pixel_addr : '0;
      valid_dly[0]   <= in_page & busy_out;
      for (int i = 1; i < DLY; i++) valid_dly[i] <= valid_dly[i-1];
    end
  end

endmodule
